mpsoc_apb_uart_regs: RTL and testbench

APB slave register file that sits directly downstream of the AHB-Lite to APB peripheral bridge and fronts the UART serial core. It decodes the 8-bit APB master interface driven by the bridge and owns the TX and RX byte FIFOs. It also holds the baud divisor, interrupt enables and overrun status. The UART shift-register core sits on the other side and exchanges bytes with this block over valid/ready streams.

---
 rtl/mpsoc_uart_pkg.sv | 38 +++
 rtl/mpsoc_apb_uart_regs_if.sv | 21 ++
 rtl/mpsoc_uart_sync_fifo.sv | 56 +++++
 rtl/mpsoc_apb_uart_regs.sv | 141 ++++++++++++++
 tb/tb_mpsoc_apb_uart_regs.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mpsoc_uart_pkg.sv
// Register offsets, STATUS/IER bit positions and reset constants shared by the UART APB register file.
package mpsoc_uart_pkg;

  localparam logic [2:0] UART_REG_DATA     = 3'd0;
  localparam logic [2:0] UART_REG_STATUS   = 3'd1;
  localparam logic [2:0] UART_REG_IER      = 3'd2;
  localparam logic [2:0] UART_REG_DIV_LO   = 3'd3;
  localparam logic [2:0] UART_REG_DIV_HI   = 3'd4;
  localparam logic [2:0] UART_REG_TXLVL    = 3'd5;
  localparam logic [2:0] UART_REG_RXLVL    = 3'd6;
  localparam logic [2:0] UART_REG_UNMAPPED = 3'd7;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_OVERRUN  = 4;

  localparam int IER_RX_AVAIL = 0;
  localparam int IER_TX_EMPTY = 1;
  localparam int IER_OVERRUN  = 2;

  localparam logic [15:0] UART_DIV_RESET = 16'h0001;

  function automatic logic [7:0] uart_status_byte(input logic tx_full, input logic tx_empty,
                                                  input logic rx_full, input logic rx_empty,
                                                  input logic overrun);
    logic [7:0] s;
    s                = 8'h00;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_RX_EMPTY] = rx_empty;
    s[STAT_OVERRUN]  = overrun;
    return s;
  endfunction

endpackage

// File: rtl/mpsoc_apb_uart_regs_if.sv
// APB slave-side bus bundle between the peripheral bridge (master) and the UART register file (slave).
interface mpsoc_apb_uart_regs_if #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic                  PSTRB;
  logic [2:0]            PPROT;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (output PSEL, PENABLE, PWRITE, PSTRB, PPROT, PADDR, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PWRITE, PSTRB, PPROT, PADDR, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/mpsoc_uart_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; a push while full is accepted only alongside a pop.
module mpsoc_uart_sync_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_en_s;
  logic             pop_en_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign pop_en_s  = pop & ~empty;
  assign push_en_s = push & (~full | pop_en_s);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata     = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_en_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_en_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_en_s, pop_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_en_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/mpsoc_apb_uart_regs.sv
// APB register file fronting the UART core: TX/RX FIFOs, baud divisor, overrun status and interrupt.
// Optional feature macro: MPSOC_UART_IRQ_EN (IER register and irq output; otherwise IER reads 0, irq tied 0).
module mpsoc_apb_uart_regs
  import mpsoc_uart_pkg::*;
#(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  mpsoc_apb_uart_regs_if.slave        apb,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  output logic [15:0]                 baud_div,
  output logic                        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  access_s, hi_err_s, err_s, wr_en_s, rd_en_s;
  logic [2:0]            offset_s;
  logic                  tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
  logic                  ovr_set_s, ovr_clr_s;
  logic                  tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
  logic [CW-1:0]         tx_count_s, rx_count_s;
  logic [7:0]            rx_head_s;
  logic [PDATA_SIZE-1:0] rdata_s;
  logic                  ovr_r;
  logic [15:0]           div_r;
  logic [2:0]            ier_r;
  logic                  irq_r;
  logic                  unused_pprot_s;

  assign unused_pprot_s = ^apb.PPROT;
  assign access_s       = apb.PSEL & apb.PENABLE;
  assign hi_err_s       = |apb.PADDR[PADDR_SIZE-1:3];
  assign offset_s       = apb.PADDR[2:0];

  // Error decode; TX-full is judged on the pre-pop state of this cycle.
  always_comb begin
    err_s = 1'b0;
    if (access_s) begin
      if (hi_err_s) begin
        err_s = 1'b1;
      end else begin
        case (offset_s)
          UART_REG_DATA:     err_s = apb.PWRITE ? (apb.PSTRB & tx_full_s) : rx_empty_s;
          UART_REG_TXLVL,
          UART_REG_RXLVL:    err_s = apb.PWRITE & apb.PSTRB;
          UART_REG_UNMAPPED: err_s = 1'b1;
          default:           err_s = 1'b0;
        endcase
      end
    end else begin
      err_s = 1'b0;
    end
  end

  assign wr_en_s   = access_s & apb.PWRITE & apb.PSTRB & ~err_s;
  assign rd_en_s   = access_s & ~apb.PWRITE & ~err_s;
  assign tx_push_s = wr_en_s & (offset_s == UART_REG_DATA);
  assign rx_pop_s  = rd_en_s & (offset_s == UART_REG_DATA);
  assign tx_pop_s  = tx_valid & tx_ready;
  // A full RX FIFO still takes the byte when the bus pops in the same cycle.
  assign rx_push_s = rx_valid & (~rx_full_s | rx_pop_s);
  assign ovr_set_s = rx_valid & rx_full_s & ~rx_pop_s;
  assign ovr_clr_s = wr_en_s & (offset_s == UART_REG_STATUS) & apb.PWDATA[STAT_OVERRUN];

  mpsoc_uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(PCLK), .rst(PRESET), .push(tx_push_s), .pop(tx_pop_s), .wdata(apb.PWDATA),
    .rdata(tx_data), .count(tx_count_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  mpsoc_uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(PCLK), .rst(PRESET), .push(rx_push_s), .pop(rx_pop_s), .wdata(rx_data),
    .rdata(rx_head_s), .count(rx_count_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // Read mux; drives zero outside a successful read access.
  always_comb begin
    rdata_s = {PDATA_SIZE{1'b0}};
    if (rd_en_s) begin
      case (offset_s)
        UART_REG_DATA:   rdata_s = rx_head_s;
        UART_REG_STATUS: rdata_s = uart_status_byte(tx_full_s, tx_empty_s, rx_full_s, rx_empty_s, ovr_r);
        UART_REG_IER:    rdata_s = {5'b00000, ier_r};
        UART_REG_DIV_LO: rdata_s = div_r[7:0];
        UART_REG_DIV_HI: rdata_s = div_r[15:8];
        UART_REG_TXLVL:  rdata_s = 8'(tx_count_s);
        UART_REG_RXLVL:  rdata_s = 8'(rx_count_s);
        default:         rdata_s = {PDATA_SIZE{1'b0}};
      endcase
    end else begin
      rdata_s = {PDATA_SIZE{1'b0}};
    end
  end

  // Divisor and sticky overrun; a same-cycle set beats the W1C clear.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ovr_r <= 1'b0;
      div_r <= UART_DIV_RESET;
    end else begin
      ovr_r <= ovr_set_s | (ovr_r & ~ovr_clr_s);
      if (wr_en_s && (offset_s == UART_REG_DIV_LO)) div_r[7:0]  <= apb.PWDATA;
      if (wr_en_s && (offset_s == UART_REG_DIV_HI)) div_r[15:8] <= apb.PWDATA;
    end
  end

`ifdef MPSOC_UART_IRQ_EN
  // Interrupt enables and the registered interrupt, one cycle behind its sources.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ier_r <= 3'b000;
      irq_r <= 1'b0;
    end else begin
      if (wr_en_s && (offset_s == UART_REG_IER)) ier_r <= apb.PWDATA[2:0];
      irq_r <= (ier_r[IER_RX_AVAIL] & ~rx_empty_s) |
               (ier_r[IER_TX_EMPTY] &  tx_empty_s) |
               (ier_r[IER_OVERRUN]  &  ovr_r);
    end
  end
`else
  assign ier_r = 3'b000;
  assign irq_r = 1'b0;
`endif

  assign apb.PRDATA  = rdata_s;
  assign apb.PSLVERR = err_s;
  assign apb.PREADY  = 1'b1;
  assign tx_valid    = ~tx_empty_s;
  assign rx_ready    = 1'b1;
  assign baud_div    = div_r;
  assign irq         = irq_r;

endmodule

// File: tb/tb_mpsoc_apb_uart_regs.sv
// Self-checking bench for mpsoc_apb_uart_regs: vector table, corner sequences and a randomized run against a queue model.
module tb_mpsoc_apb_uart_regs;

  localparam int DEPTH = 16;
`ifdef MPSOC_UART_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
  logic [15:0] baud_div;

  always #5 PCLK = ~PCLK;

  mpsoc_apb_uart_regs_if #(.PADDR_SIZE(10), .PDATA_SIZE(8)) apb_if ();

  mpsoc_apb_uart_regs #(.PADDR_SIZE(10), .PDATA_SIZE(8), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .apb(apb_if.slave),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .baud_div(baud_div), .irq(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0]  tx_q[$];
  logic [7:0]  rx_q[$];
  bit          m_ovr;
  logic [2:0]  m_ier;
  logic [15:0] m_div;
  bit          m_irq;
  bit          model_on = 1'b0;
  bit          rnd_side = 1'b0;

  // Values sampled at the last negedge
  logic [7:0] s_rd, s_txd;
  logic       s_err, s_irq, s_txv;

  typedef struct {
    bit         w;
    logic [9:0] a;
    logic [7:0] d;
    bit         s;
    logic [7:0] e_rd;
    bit         e_err;
  } vec_t;
  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit exp_err();
    logic [2:0] off;
    off = apb_if.PADDR[2:0];
    if (!(apb_if.PSEL && apb_if.PENABLE)) return 1'b0;
    if (apb_if.PADDR[9:3] != 7'd0) return 1'b1;
    if (off == 3'd7) return 1'b1;
    if (apb_if.PWRITE && apb_if.PSTRB)
      return (off == 3'd0 && tx_q.size() == DEPTH) || off == 3'd5 || off == 3'd6;
    if (!apb_if.PWRITE) return (off == 3'd0 && rx_q.size() == 0);
    return 1'b0;
  endfunction

  function automatic logic [7:0] exp_rdata();
    if (!(apb_if.PSEL && apb_if.PENABLE) || apb_if.PWRITE || exp_err()) return 8'h00;
    case (apb_if.PADDR[2:0])
      3'd0: return rx_q[0];
      3'd1: return {3'b000, m_ovr, rx_q.size() == 0, rx_q.size() == DEPTH,
                    tx_q.size() == 0, tx_q.size() == DEPTH};
      3'd2: return {5'b00000, m_ier};
      3'd3: return m_div[7:0];
      3'd4: return m_div[15:8];
      3'd5: return 8'(tx_q.size());
      3'd6: return 8'(rx_q.size());
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_check();
    check("prdata", apb_if.PRDATA, exp_rdata());
    check("pslverr", apb_if.PSLVERR, exp_err());
    check("pready", apb_if.PREADY, 1'b1);
    check("rx_ready", rx_ready, 1'b1);
    check("tx_valid", tx_valid, tx_q.size() != 0);
    if (tx_q.size() != 0) check("tx_data", tx_data, tx_q[0]);
    check("baud_div", baud_div, m_div);
    check("irq", irq, m_irq);
  endtask

  // Advance the model over one clock edge using the inputs applied during that cycle.
  task automatic model_edge();
    bit         acc, er, wr, rd, rx_full_pre, irq_n;
    logic [2:0] off;
    acc         = apb_if.PSEL && apb_if.PENABLE;
    er          = exp_err();
    off         = apb_if.PADDR[2:0];
    wr          = acc && apb_if.PWRITE && apb_if.PSTRB && !er;
    rd          = acc && !apb_if.PWRITE && !er;
    rx_full_pre = (rx_q.size() == DEPTH);
    irq_n = (m_ier[0] && rx_q.size() != 0) || (m_ier[1] && tx_q.size() == 0) || (m_ier[2] && m_ovr);
    if (tx_q.size() != 0 && tx_ready) void'(tx_q.pop_front());
    if (wr && off == 3'd0) tx_q.push_back(apb_if.PWDATA);
    if (rd && off == 3'd0) void'(rx_q.pop_front());
    if (rx_valid && rx_full_pre && !(rd && off == 3'd0)) m_ovr = 1'b1;
    else if (wr && off == 3'd1 && apb_if.PWDATA[4]) m_ovr = 1'b0;
    if (rx_valid && (!rx_full_pre || (rd && off == 3'd0))) rx_q.push_back(rx_data);
    if (wr && off == 3'd3) m_div[7:0]  = apb_if.PWDATA;
    if (wr && off == 3'd4) m_div[15:8] = apb_if.PWDATA;
    if (IRQ_ON) begin
      if (wr && off == 3'd2) m_ier = apb_if.PWDATA[2:0];
      m_irq = irq_n;
    end
  endtask

  // One clock: sample/check at negedge, update the model at posedge, return at posedge+1.
  task automatic tick();
    if (rnd_side) begin
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      tx_ready = 1'($urandom_range(0, 1));
    end
    @(negedge PCLK);
    s_rd  = apb_if.PRDATA;
    s_err = apb_if.PSLVERR;
    s_irq = irq;
    s_txv = tx_valid;
    s_txd = tx_data;
    if (model_on) model_check();
    @(posedge PCLK);
    if (model_on) model_edge();
    #1;
  endtask

  task automatic xfer(input bit w, input logic [9:0] a, input logic [7:0] d, input bit s,
                      input bit rxv = 1'b0, input logic [7:0] rxd = 8'h00, input bit txr = 1'b0);
    apb_if.PSEL    = 1'b1;
    apb_if.PENABLE = 1'b0;
    apb_if.PWRITE  = w;
    apb_if.PADDR   = a;
    apb_if.PWDATA  = d;
    apb_if.PSTRB   = s;
    tick();
    apb_if.PENABLE = 1'b1;
    if (!rnd_side) begin
      rx_valid = rxv;
      rx_data  = rxd;
      tx_ready = txr;
    end
    tick();
    apb_if.PSEL    = 1'b0;
    apb_if.PENABLE = 1'b0;
    if (!rnd_side) begin
      rx_valid = 1'b0;
      tx_ready = 1'b0;
    end
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    PRESET   = 1'b1;
    repeat (2) @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    tx_q.delete();
    rx_q.delete();
    m_ovr    = 1'b0;
    m_ier    = 3'b000;
    m_div    = 16'h0001;
    m_irq    = 1'b0;
    model_on = 1'b1;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    PRESET = 1'b1;
    apb_if.PSEL = 1'b0; apb_if.PENABLE = 1'b0; apb_if.PWRITE = 1'b0; apb_if.PSTRB = 1'b0;
    apb_if.PPROT = 3'b000; apb_if.PADDR = 10'h000; apb_if.PWDATA = 8'h00;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

    do_reset();
    tick();
    check("reset_prdata", s_rd, 8'h00);
    check("reset_pslverr", s_err, 1'b0);
    check("reset_tx_valid", s_txv, 1'b0);
    check("reset_tx_data", s_txd, 8'h00);
    check("reset_irq", s_irq, 1'b0);

    // Vector table: APB accesses with no core-side activity
    vt.push_back('{1'b0, 10'd1, 8'h00, 1'b1, 8'h0A, 1'b0});
    vt.push_back('{1'b0, 10'd3, 8'h00, 1'b1, 8'h01, 1'b0});
    vt.push_back('{1'b0, 10'd4, 8'h00, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b1, 10'd3, 8'h34, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b1, 10'd4, 8'h12, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b0, 10'd3, 8'h00, 1'b1, 8'h34, 1'b0});
    vt.push_back('{1'b0, 10'd4, 8'h00, 1'b1, 8'h12, 1'b0});
    vt.push_back('{1'b1, 10'd0, 8'h55, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b1, 10'd0, 8'hAA, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b0, 10'd5, 8'h00, 1'b1, 8'h02, 1'b0});
    vt.push_back('{1'b0, 10'd1, 8'h00, 1'b1, 8'h08, 1'b0});
    vt.push_back('{1'b1, 10'd5, 8'h99, 1'b1, 8'h00, 1'b1});
    vt.push_back('{1'b0, 10'd7, 8'h00, 1'b1, 8'h00, 1'b1});
    vt.push_back('{1'b0, 10'h009, 8'h00, 1'b1, 8'h00, 1'b1});
    vt.push_back('{1'b0, 10'd0, 8'h00, 1'b1, 8'h00, 1'b1});
    vt.push_back('{1'b1, 10'd0, 8'h77, 1'b0, 8'h00, 1'b0});
    vt.push_back('{1'b0, 10'd5, 8'h00, 1'b1, 8'h02, 1'b0});
    vt.push_back('{1'b1, 10'd2, 8'h05, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b0, 10'd2, 8'h00, 1'b1, IRQ_ON ? 8'h05 : 8'h00, 1'b0});
    vt.push_back('{1'b1, 10'd2, 8'h00, 1'b1, 8'h00, 1'b0});
    vt.push_back('{1'b0, 10'd6, 8'h00, 1'b1, 8'h00, 1'b0});
    foreach (vt[i]) begin
      xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s);
      check($sformatf("vec%0d_rdata", i), s_rd, vt[i].e_rd);
      check($sformatf("vec%0d_err", i), s_err, vt[i].e_err);
    end

    // TX drain order with tx_ready held for two cycles
    tick();
    check("tx_head", s_txd, 8'h55);
    tx_ready = 1'b1;
    tick();
    check("tx_seq0", s_txd, 8'h55);
    tick();
    check("tx_seq1", s_txd, 8'hAA);
    tx_ready = 1'b0;
    tick();
    check("tx_drained", s_txv, 1'b0);
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("tx_empty_status", s_rd, 8'h0A);

    // TX overflow, then a push into a full FIFO while the core pops
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b1, 10'd0, 8'(i + 8'h30), 1'b1);
      check("tx_fill_err", s_err, 1'b0);
    end
    xfer(1'b1, 10'd0, 8'hEE, 1'b1);
    check("tx_17th_err", s_err, 1'b1);
    xfer(1'b0, 10'd5, 8'h00, 1'b1);
    check("tx_lvl_full", s_rd, 8'h10);
    xfer(1'b1, 10'd0, 8'hEF, 1'b1, 1'b0, 8'h00, 1'b1);
    check("tx_full_pop_err", s_err, 1'b1);
    xfer(1'b0, 10'd5, 8'h00, 1'b1);
    check("tx_lvl_after_pop", s_rd, 8'h0F);
    tx_ready = 1'b1;
    repeat (DEPTH) tick();
    tx_ready = 1'b0;

    // RX overflow, sequential reads, underflow, W1C
    for (int i = 0; i <= DEPTH; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i);
      tick();
    end
    rx_valid = 1'b0;
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("rx_ovr_status", s_rd, 8'h16);
    xfer(1'b0, 10'd6, 8'h00, 1'b1);
    check("rx_lvl_full", s_rd, 8'h10);
    for (int i = 0; i < DEPTH; i++) begin
      xfer(1'b0, 10'd0, 8'h00, 1'b1);
      check($sformatf("rx_read%0d", i), s_rd, 8'(i));
    end
    xfer(1'b0, 10'd0, 8'h00, 1'b1);
    check("rx_empty_err", s_err, 1'b1);
    check("rx_empty_rdata", s_rd, 8'h00);
    xfer(1'b1, 10'd1, 8'h10, 1'b1);
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("ovr_cleared", s_rd, 8'h0A);

    // Pop coinciding with full accepts the push; set beats W1C clear
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(i + 8'h20);
      tick();
    end
    rx_valid = 1'b0;
    xfer(1'b0, 10'd0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0);
    check("pop_full_data", s_rd, 8'h20);
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("pop_full_no_ovr", s_rd, 8'h06);
    xfer(1'b1, 10'd1, 8'h10, 1'b1, 1'b1, 8'hD4, 1'b0);
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("ovr_set_wins", s_rd, 8'h16);
    xfer(1'b1, 10'd1, 8'h10, 1'b1);
    repeat (DEPTH) xfer(1'b0, 10'd0, 8'h00, 1'b1);
    check("rx_last_byte", s_rd, 8'hC3);

    // Interrupt latency on the rx-available source
    xfer(1'b1, 10'd2, 8'h01, 1'b1);
    rx_valid = 1'b1;
    rx_data  = 8'h42;
    tick();
    rx_valid = 1'b0;
    tick();
    check("irq_not_yet", s_irq, 1'b0);
    tick();
    check("irq_rise", s_irq, IRQ_ON);
    xfer(1'b0, 10'd0, 8'h00, 1'b1);
    check("irq_rx_data", s_rd, 8'h42);
    tick();
    check("irq_hold", s_irq, IRQ_ON);
    tick();
    check("irq_fall", s_irq, 1'b0);
    xfer(1'b1, 10'd2, 8'h00, 1'b1);

    // Reset in the middle of traffic discards FIFO contents
    xfer(1'b1, 10'd0, 8'h11, 1'b1, 1'b1, 8'h22, 1'b0);
    xfer(1'b1, 10'd3, 8'h99, 1'b1);
    do_reset();
    xfer(1'b0, 10'd1, 8'h00, 1'b1);
    check("midreset_status", s_rd, 8'h0A);
    xfer(1'b0, 10'd3, 8'h00, 1'b1);
    check("midreset_div", s_rd, 8'h01);

    // Randomized traffic checked every cycle by the model
    rnd_side = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [9:0] a;
      if ($urandom_range(0, 1) == 0) a = 10'd0;
      else if ($urandom_range(0, 9) == 0) a = 10'(8 + $urandom_range(0, 7));
      else a = 10'($urandom_range(0, 7));
      xfer(1'($urandom_range(0, 1)), a, 8'($urandom), ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_side = 1'b0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
